// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined shift unit: operation encodings and a
// width helper used to size the shift amount / pipeline depth.
package shift_pkg;

    typedef logic [1:0] shift_mode_t;

    localparam shift_mode_t SHIFT_SLL = 2'b00;
    localparam shift_mode_t SHIFT_SRL = 2'b01;
    localparam shift_mode_t SHIFT_SRA = 2'b10;
    localparam shift_mode_t SHIFT_ROR = 2'b11;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline stage of the shift unit: conditionally shifts/rotates by STEP,
// then registers data, mode, remaining amount and valid.
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH   = 12,
    parameter int SHAMT_W = 4,
    parameter int STEP    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_en,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [WIDTH-1:0]   i_data,
    input  shift_mode_t        i_mode,
    input  logic [SHAMT_W-1:0] i_amt,
    output logic               o_valid,
    output logic [WIDTH-1:0]   o_data,
    output shift_mode_t        o_mode,
    output logic [SHAMT_W-1:0] o_amt
);

    // Rotating by STEP mod WIDTH makes over-range ROR amounts compose correctly.
    localparam int ROT = STEP % WIDTH;

    logic [WIDTH-1:0]   w_rot;
    logic [WIDTH-1:0]   w_next;
    logic               r_valid;
    logic [WIDTH-1:0]   r_data;
    shift_mode_t        r_mode;
    logic [SHAMT_W-1:0] r_amt;

    assign w_rot = (i_data >> ROT) | (i_data << (WIDTH - ROT));

    always_comb begin
        w_next = i_data;
        if (i_amt[0]) begin
            case (i_mode)
                SHIFT_SLL: w_next = i_data << STEP;
                SHIFT_SRL: w_next = i_data >> STEP;
                SHIFT_SRA: w_next = $signed(i_data) >>> STEP;
                default:   w_next = w_rot;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_mode  <= SHIFT_SLL;
            r_amt   <= '0;
        end else begin
            if (i_flush)
                r_valid <= 1'b0;
            else if (i_en)
                r_valid <= i_valid;
            if (i_en) begin
                r_data <= w_next;
                r_mode <= i_mode;
                r_amt  <= i_amt >> 1;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_mode  = r_mode;
    assign o_amt   = r_amt;

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined SLL/SRL/SRA/ROR shifter, one stage per shift-amount bit, with
// valid/ready handshaking, global stall and synchronous flush.
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter  int WIDTH   = 12,
    localparam int SHAMT_W = clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [SHAMT_W-1:0] op_b,
    input  logic [1:0]         op_mode,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   op_c,
    output logic               zero_flag
);

    logic                     w_stall;
    logic [SHAMT_W:0]         w_valid;
    logic [WIDTH-1:0]         w_data [SHAMT_W+1];
    shift_mode_t              w_mode [SHAMT_W+1];
    logic [SHAMT_W-1:0]       w_amt  [SHAMT_W+1];

    // A held result freezes the whole pipe; bubbles are kept, never collapsed.
    assign w_stall  = w_valid[SHAMT_W] && !out_ready;
    assign in_ready = !w_stall && !flush;

    assign w_valid[0] = in_valid && in_ready;
    assign w_data[0]  = op_a;
    assign w_mode[0]  = op_mode;
    assign w_amt[0]   = op_b;

    for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
        shift_stage #(
            .WIDTH   (WIDTH),
            .SHAMT_W (SHAMT_W),
            .STEP    (1 << k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (!w_stall),
            .i_flush (flush),
            .i_valid (w_valid[k]),
            .i_data  (w_data[k]),
            .i_mode  (w_mode[k]),
            .i_amt   (w_amt[k]),
            .o_valid (w_valid[k+1]),
            .o_data  (w_data[k+1]),
            .o_mode  (w_mode[k+1]),
            .o_amt   (w_amt[k+1])
        );
    end

    assign out_valid = w_valid[SHAMT_W];
    assign op_c      = w_data[SHAMT_W];
    assign zero_flag = out_valid && (op_c == '0);

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed bench for shift_unit_pipe (WIDTH=12): vector table plus
// backpressure, flush and mid-flight reset sequences.
module tb_shift_unit_pipe;
    import shift_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] op_a = '0;
    logic [3:0]  op_b = '0;
    logic [1:0]  op_mode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [11:0] op_c;
    logic        zero_flag;

    int n_run  = 0;
    int n_fail = 0;

    typedef struct {
        logic [1:0]  mode;
        logic [11:0] a;
        logic [3:0]  b;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [16];

    shift_unit_pipe #(.WIDTH(12)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_mode   (op_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .op_c      (op_c),
        .zero_flag (zero_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one op, expect it on the 4th edge counting the accept edge.
    task automatic run_one(input vec_t v, input string name);
        op_mode   = v.mode;
        op_a      = v.a;
        op_b      = v.b;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        chk({name, " in_ready"}, 32'(in_ready), 32'd1);
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        chk({name, " early"}, 32'(out_valid), 32'd0);
        tick;
        chk({name, " valid"}, 32'(out_valid), 32'd1);
        chk({name, " data"}, 32'(op_c), 32'(v.exp));
        chk({name, " zero"}, 32'(zero_flag), 32'(v.exp == 12'h000));
        tick;
        chk({name, " drained"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [11:0] hold;
        int sent;
        int got;
        logic acc;
        vec_t v;

        vecs[0]  = '{SHIFT_SLL, 12'h00F, 4'd4,  12'h0F0};
        vecs[1]  = '{SHIFT_SRL, 12'h800, 4'd3,  12'h100};
        vecs[2]  = '{SHIFT_SRA, 12'h800, 4'd3,  12'hF00};
        vecs[3]  = '{SHIFT_ROR, 12'h001, 4'd13, 12'h800};
        vecs[4]  = '{SHIFT_SLL, 12'hFFF, 4'd12, 12'h000};
        vecs[5]  = '{SHIFT_SRA, 12'h800, 4'd15, 12'hFFF};
        vecs[6]  = '{SHIFT_SRL, 12'h7FF, 4'd15, 12'h000};
        vecs[7]  = '{SHIFT_SLL, 12'hABC, 4'd0,  12'hABC};
        vecs[8]  = '{SHIFT_ROR, 12'hABC, 4'd0,  12'hABC};
        vecs[9]  = '{SHIFT_SRA, 12'h7FF, 4'd1,  12'h3FF};
        vecs[10] = '{SHIFT_ROR, 12'h123, 4'd4,  12'h312};
        vecs[11] = '{SHIFT_SRA, 12'h9A5, 4'd2,  12'hE69};
        vecs[12] = '{SHIFT_ROR, 12'h801, 4'd15, 12'h300};
        vecs[13] = '{SHIFT_SLL, 12'h001, 4'd11, 12'h800};
        vecs[14] = '{SHIFT_SRL, 12'hFFF, 4'd11, 12'h001};
        vecs[15] = '{SHIFT_SRA, 12'h700, 4'd8,  12'h007};

        // Reset state
        tick;
        tick;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset op_c", 32'(op_c), 32'd0);
        chk("reset zero_flag", 32'(zero_flag), 32'd0);
        rst_n = 1'b1;
        tick;
        chk("post-reset in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 16; i++)
            run_one(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: 6 ops, out_ready low for cycles 5..7
        sent = 0;
        got  = 0;
        hold = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            out_ready = !(cyc >= 5 && cyc <= 7);
            in_valid  = (sent < 6);
            op_mode   = SHIFT_SLL;
            op_a      = 12'h001;
            op_b      = 4'(sent + 1);
            #1;
            if (cyc == 5) begin
                chk("bp stall valid", 32'(out_valid), 32'd1);
                hold = op_c;
            end
            if (cyc >= 5 && cyc <= 7)
                chk($sformatf("bp in_ready c%0d", cyc), 32'(in_ready), 32'd0);
            if (cyc == 6 || cyc == 7)
                chk($sformatf("bp hold c%0d", cyc), 32'(op_c), 32'(hold));
            if (out_valid && out_ready) begin
                if (got < 6)
                    chk($sformatf("bp result%0d", got), 32'(op_c), 32'(12'h002 << got));
                got++;
            end
            acc = in_valid && in_ready;
            tick;
            if (acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp sent", 32'(sent), 32'd6);
        chk("bp received", 32'(got), 32'd6);

        // Flush with 3 ops in flight and a competing in_valid
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            op_mode  = SHIFT_SLL;
            op_a     = 12'h001;
            op_b     = 4'(i);
            tick;
        end
        flush   = 1'b1;
        op_a    = 12'h555;
        op_b    = 4'd0;
        #1;
        chk("flush in_ready", 32'(in_ready), 32'd0);
        tick;
        flush    = 1'b0;
        in_valid = 1'b0;
        for (int i = 0; i < 8; i++)
            chk($sformatf("flush quiet%0d", i), 32'(out_valid), 32'd0);
        v = '{SHIFT_SRL, 12'hABC, 4'd4, 12'h0AB};
        run_one(v, "post-flush");

        // Flush while the output stage is stalled
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op_mode   = SHIFT_SLL;
        op_a      = 12'h003;
        op_b      = 4'd1;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        tick;
        chk("flush-stall valid", 32'(out_valid), 32'd1);
        flush = 1'b1;
        tick;
        flush = 1'b0;
        chk("flush-stall cleared", 32'(out_valid), 32'd0);
        out_ready = 1'b1;

        // Async reset with 2 ops in flight, first one held at the output
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            op_mode  = SHIFT_SLL;
            op_a     = 12'h001;
            op_b     = 4'(i + 1);
            tick;
        end
        in_valid = 1'b0;
        tick;
        tick;
        chk("rst pre valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst async valid", 32'(out_valid), 32'd0);
        chk("rst async op_c", 32'(op_c), 32'd0);
        chk("rst async zero", 32'(zero_flag), 32'd0);
        tick;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rst quiet%0d", i), 32'(out_valid), 32'd0);
            tick;
        end
        v = '{SHIFT_ROR, 12'h00F, 4'd2, 12'hC03};
        run_one(v, "post-reset");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
